// File: rtl/line_buffer_window_gen_if.sv
// Valid/ready bundle for line_buffer_window_gen: pixel input side and window output side.
// Defining LBW_COORD_EN adds the window top-left coordinate signals.
interface line_buffer_window_gen_if #(
  parameter int unsigned PW = 8,
  parameter int unsigned WW = 200
`ifdef LBW_COORD_EN
  ,
  parameter int unsigned XW = 5,
  parameter int unsigned YW = 5
`endif
);
  logic          i_sof;
  logic          i_valid;
  logic [PW-1:0] i_pixel;
  logic          o_ready;
  logic          o_win_valid;
  logic          i_win_ready;
  logic [WW-1:0] o_window;
  logic          o_frame_done;
`ifdef LBW_COORD_EN
  logic [XW-1:0] o_win_x;
  logic [YW-1:0] o_win_y;
`endif

  modport slave (
    input  i_sof, i_valid, i_pixel, i_win_ready,
    output o_ready, o_win_valid, o_window, o_frame_done
`ifdef LBW_COORD_EN
    , output o_win_x, o_win_y
`endif
  );

  modport master (
    output i_sof, i_valid, i_pixel, i_win_ready,
    input  o_ready, o_win_valid, o_window, o_frame_done
`ifdef LBW_COORD_EN
    , input o_win_x, o_win_y
`endif
  );
endinterface

// File: rtl/line_buffer_window_gen.sv
// Streaming KX x KY sliding-window generator over raster pixels, KY-1 line buffer, strided output.
// Optional macro LBW_COORD_EN adds o_win_x/o_win_y (top-left coordinate of the held window).
module line_buffer_window_gen #(
  parameter int unsigned I_F_BW = 8,
  parameter int unsigned CI     = 1,
  parameter int unsigned KX     = 5,
  parameter int unsigned KY     = 5,
  parameter int unsigned IX     = 28,
  parameter int unsigned IY     = 28,
  parameter int unsigned STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  line_buffer_window_gen_if.slave bus
);
  localparam int unsigned PW       = CI * I_F_BW;
  localparam int unsigned LW       = (KY - 1) * PW;
  localparam int unsigned WW       = KX * KY * PW;
  localparam int unsigned CW       = $clog2(IX);
  localparam int unsigned RW       = $clog2(IY);
  localparam int unsigned LAST_COL = (KX - 1) + ((IX - KX) / STRIDE) * STRIDE;
  localparam int unsigned LAST_ROW = (KY - 1) + ((IY - KY) / STRIDE) * STRIDE;

  logic [LW-1:0]   r_lb [IX];
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [WW-1:0]   r_shift;
  logic [WW-1:0]   r_window;
  logic            r_win_valid;
  logic            r_win_last;

  logic            w_accept;
  logic            w_emit;
  logic            w_last;
  logic            w_win_valid_nxt;
  logic [CW-1:0]   w_col;
  logic [CW-1:0]   w_col_nxt;
  logic [CW-1:0]   w_col_off;
  logic [RW-1:0]   w_row;
  logic [RW-1:0]   w_row_nxt;
  logic [RW-1:0]   w_row_off;
  logic [LW-1:0]   w_lb_rd;
  logic [LW-1:0]   w_lb_wr;
  logic [KY*PW-1:0] w_column;
  logic [WW-1:0]   w_shift_nxt;

  // Input is only stalled while an unaccepted window is held.
  assign bus.o_ready      = !r_win_valid || bus.i_win_ready;
  assign bus.o_win_valid  = r_win_valid;
  assign bus.o_window     = r_window;
  assign bus.o_frame_done = r_win_valid && bus.i_win_ready && r_win_last;

  assign w_accept = bus.i_valid && bus.o_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of the running counters.
  assign w_col = bus.i_sof ? '0 : r_col;
  assign w_row = bus.i_sof ? '0 : r_row;

  assign w_lb_rd = r_lb[w_col];
  assign w_lb_wr = w_column[KY*PW-1:PW];

  always_comb begin
    w_column = '0;
    for (int unsigned ky = 0; ky < KY - 1; ky++) begin
      w_column[ky*PW +: PW] = w_lb_rd[ky*PW +: PW];
    end
    w_column[(KY-1)*PW +: PW] = bus.i_pixel;
  end

  // Window shift register moves one column left; the new column enters at kx = KX-1.
  always_comb begin
    w_shift_nxt = r_shift;
    for (int unsigned ky = 0; ky < KY; ky++) begin
      for (int unsigned kx = 0; kx < KX - 1; kx++) begin
        w_shift_nxt[(ky*KX+kx)*PW +: PW] = r_shift[(ky*KX+kx+1)*PW +: PW];
      end
      w_shift_nxt[(ky*KX+KX-1)*PW +: PW] = w_column[ky*PW +: PW];
    end
  end

  assign w_col_off = w_col - CW'(KX - 1);
  assign w_row_off = w_row - RW'(KY - 1);
  assign w_emit    = (w_col >= CW'(KX - 1)) && (w_row >= RW'(KY - 1)) &&
                     ((w_col_off % CW'(STRIDE)) == '0) &&
                     ((w_row_off % RW'(STRIDE)) == '0);
  assign w_last    = (w_col == CW'(LAST_COL)) && (w_row == RW'(LAST_ROW));

  always_comb begin
    w_col_nxt = w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_col == CW'(IX - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == RW'(IY - 1)) ? '0 : w_row + 1'b1;
    end
  end

  // A window loaded in the same cycle as an accept wins over the clear.
  always_comb begin
    w_win_valid_nxt = r_win_valid;
    if (bus.i_win_ready) begin
      w_win_valid_nxt = 1'b0;
    end
    if (w_accept && w_emit) begin
      w_win_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_window    <= '0;
    end else begin
      r_win_valid <= w_win_valid_nxt;
      if (w_accept) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
      end
      if (w_accept && w_emit) begin
        r_window   <= w_shift_nxt;
        r_win_last <= w_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift     <= w_shift_nxt;
      r_lb[w_col] <= w_lb_wr;
    end
  end

`ifdef LBW_COORD_EN
  logic [CW-1:0] r_win_x;
  logic [RW-1:0] r_win_y;

  assign bus.o_win_x = r_win_x;
  assign bus.o_win_y = r_win_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_x <= '0;
      r_win_y <= '0;
    end else if (w_accept && w_emit) begin
      r_win_x <= w_col_off;
      r_win_y <= w_row_off;
    end
  end
`endif
endmodule

// File: tb/tb_line_buffer_window_gen.sv
// Bench for line_buffer_window_gen: three configurations checked against an image-level window model.
// Honours LBW_COORD_EN when defined for the build.
module tb_line_buffer_window_gen;
  typedef struct {
    logic [255:0] w;
    bit           last;
    int           x;
    int           y;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef LBW_COORD_EN
  line_buffer_window_gen_if #(.PW(8),  .WW(200), .XW(5), .YW(5)) a_if();
  line_buffer_window_gen_if #(.PW(8),  .WW(200), .XW(5), .YW(5)) b_if();
  line_buffer_window_gen_if #(.PW(24), .WW(216), .XW(3), .YW(3)) c_if();
`else
  line_buffer_window_gen_if #(.PW(8),  .WW(200)) a_if();
  line_buffer_window_gen_if #(.PW(8),  .WW(200)) b_if();
  line_buffer_window_gen_if #(.PW(24), .WW(216)) c_if();
`endif

  line_buffer_window_gen u_a (.clk(clk), .reset(reset), .bus(a_if));
  line_buffer_window_gen #(.STRIDE(2)) u_b (.clk(clk), .reset(reset), .bus(b_if));
  line_buffer_window_gen #(.CI(3), .KX(3), .KY(3), .IX(6), .IY(6)) u_c (.clk(clk), .reset(reset), .bus(c_if));

  int n_tests = 0;
  int n_fail  = 0;

  int kxd[3] = '{5, 5, 3};
  int kyd[3] = '{5, 5, 3};
  int cid[3] = '{1, 1, 3};
  int ixd[3] = '{28, 28, 6};
  int iyd[3] = '{28, 28, 6};
  int sd[3]  = '{1, 2, 1};

  logic [23:0]  img [3][28][28];
  int           mr[3];
  int           mc[3];
  exp_t         expq[3][$];
  logic [255:0] cap[3][$];
  logic [255:0] ref_a[$];
  int           hs_cnt[3];
  int           fd_cnt[3];
  logic [255:0] prev_win[3];
  bit           prev_stall[3];
  int           stall_cnt = 0;
  int           last_x = -1;
  int           last_y = -1;
  bit           bp = 1'b0;

  task automatic chk(input string name, input int d, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  task automatic chki(input string name, input int d, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
    end
  endtask

  function automatic logic [7:0] elem(input logic [255:0] w, input int kxn, input int ci,
                                      input int ky, input int kx, input int ch);
    return w[((ky*kxn+kx)*ci+ch)*8 +: 8];
  endfunction

  function automatic logic [255:0] get_cap(input int d, input int i);
    if (i < cap[d].size()) return cap[d][i];
    return '1;
  endfunction

  function automatic logic [23:0] pix(input int kind, input int i);
    case (kind)
      0:       pix = {16'h0, 8'((i + 1) % 256)};
      1:       pix = {8'(i + 128), 8'(i + 64), 8'(i)};
      default: pix = {16'h0, 8'((i * 3 + 7) % 256)};
    endcase
  endfunction

  // Model: keep the frame as a 2D image; every accepted pixel that completes a
  // stride-aligned window queues the window cut directly from that image.
  task automatic model_accept(input int d, input logic [23:0] px, input logic sof);
    int r, c, r0, c0;
    exp_t e;
    if (sof) begin
      mr[d] = 0;
      mc[d] = 0;
    end
    r = mr[d];
    c = mc[d];
    img[d][r][c] = px;
    if (r >= kyd[d] - 1 && c >= kxd[d] - 1 &&
        (c - kxd[d] + 1) % sd[d] == 0 && (r - kyd[d] + 1) % sd[d] == 0) begin
      r0 = r - kyd[d] + 1;
      c0 = c - kxd[d] + 1;
      e.w = '0;
      for (int ky = 0; ky < kyd[d]; ky++)
        for (int kx = 0; kx < kxd[d]; kx++)
          for (int ch = 0; ch < cid[d]; ch++)
            e.w[((ky*kxd[d]+kx)*cid[d]+ch)*8 +: 8] = img[d][r0+ky][c0+kx][ch*8 +: 8];
      e.last = (c0 / sd[d] == (ixd[d] - kxd[d]) / sd[d]) && (r0 / sd[d] == (iyd[d] - kyd[d]) / sd[d]);
      e.x = c0;
      e.y = r0;
      expq[d].push_back(e);
    end
    c++;
    if (c == ixd[d]) begin
      c = 0;
      r++;
      if (r == iyd[d]) r = 0;
    end
    mr[d] = r;
    mc[d] = c;
  endtask

  // Single compare process: scoreboard, handshake rules and model update.
  always @(negedge clk) begin
    logic         vld [3];
    logic         rdy [3];
    logic         ordy [3];
    logic         fd [3];
    logic         ivld [3];
    logic         isof [3];
    logic [23:0]  px [3];
    logic [255:0] win [3];
    int           cx [3];
    int           cy [3];
    vld[0] = a_if.o_win_valid;  vld[1] = b_if.o_win_valid;  vld[2] = c_if.o_win_valid;
    rdy[0] = a_if.i_win_ready;  rdy[1] = b_if.i_win_ready;  rdy[2] = c_if.i_win_ready;
    ordy[0] = a_if.o_ready;     ordy[1] = b_if.o_ready;     ordy[2] = c_if.o_ready;
    fd[0] = a_if.o_frame_done;  fd[1] = b_if.o_frame_done;  fd[2] = c_if.o_frame_done;
    ivld[0] = a_if.i_valid;     ivld[1] = b_if.i_valid;     ivld[2] = c_if.i_valid;
    isof[0] = a_if.i_sof;       isof[1] = b_if.i_sof;       isof[2] = c_if.i_sof;
    px[0] = {16'h0, a_if.i_pixel};
    px[1] = {16'h0, b_if.i_pixel};
    px[2] = c_if.i_pixel;
    win[0] = 256'(a_if.o_window);
    win[1] = 256'(b_if.o_window);
    win[2] = 256'(c_if.o_window);
`ifdef LBW_COORD_EN
    cx[0] = int'(a_if.o_win_x); cy[0] = int'(a_if.o_win_y);
    cx[1] = int'(b_if.o_win_x); cy[1] = int'(b_if.o_win_y);
    cx[2] = int'(c_if.o_win_x); cy[2] = int'(c_if.o_win_y);
`else
    for (int d = 0; d < 3; d++) begin
      cx[d] = 0;
      cy[d] = 0;
    end
`endif
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        expq[d].delete();
        mr[d] = 0;
        mc[d] = 0;
        prev_stall[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        exp_t e;
        chki("o_ready_rule", d, int'(ordy[d]), int'(!vld[d] || rdy[d]));
        if (d == 0 && !ordy[d]) stall_cnt++;
        if (prev_stall[d]) begin
          chki("held_valid", d, int'(vld[d]), 1);
          chk("held_window", d, win[d], prev_win[d]);
        end
        if (vld[d] && rdy[d]) begin
          if (expq[d].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_window dut%0d: got %0h, expected no window", d, win[d]);
          end else begin
            e = expq[d].pop_front();
            chk("window", d, win[d], e.w);
            chki("frame_done", d, int'(fd[d]), int'(e.last));
`ifdef LBW_COORD_EN
            chki("win_x", d, cx[d], e.x);
            chki("win_y", d, cy[d], e.y);
`endif
          end
          hs_cnt[d]++;
          cap[d].push_back(win[d]);
          if (d == 0) begin
            last_x = cx[d];
            last_y = cy[d];
          end
        end else begin
          chki("frame_done_idle", d, int'(fd[d]), 0);
        end
        if (fd[d]) fd_cnt[d]++;
        prev_stall[d] = vld[d] && !rdy[d];
        prev_win[d]   = win[d];
        if (ivld[d] && ordy[d]) model_accept(d, px[d], isof[d]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp) a_if.i_win_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog dut0: got timeout, expected run to finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    for (int d = 0; d < 3; d++) begin
      hs_cnt[d] = 0;
      fd_cnt[d] = 0;
      cap[d].delete();
    end
  endtask

  task automatic stream(input bit [2:0] mask, input int n, input int kind, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      logic [23:0] p;
      bit [2:0]    pend;
      int          g;
      p = pix(kind, i);
      pend = mask;
      g = 0;
      while (pend != 3'b000) begin
        a_if.i_valid = pend[0]; a_if.i_pixel = p[7:0]; a_if.i_sof = sof_first && (i == 0);
        b_if.i_valid = pend[1]; b_if.i_pixel = p[7:0]; b_if.i_sof = sof_first && (i == 0);
        c_if.i_valid = pend[2]; c_if.i_pixel = p;      c_if.i_sof = sof_first && (i == 0);
        @(negedge clk);
        if (pend[0] && a_if.o_ready) pend[0] = 1'b0;
        if (pend[1] && b_if.o_ready) pend[1] = 1'b0;
        if (pend[2] && c_if.o_ready) pend[2] = 1'b0;
        @(posedge clk);
        #1;
        g++;
        if (g > 1000) begin
          n_tests++;
          n_fail++;
          $display("FAIL accept_timeout dut0: got no accept, expected pixel %0d accepted", i);
          pend = 3'b000;
        end
      end
    end
    a_if.i_valid = 1'b0; a_if.i_sof = 1'b0;
    b_if.i_valid = 1'b0; b_if.i_sof = 1'b0;
    c_if.i_valid = 1'b0; c_if.i_sof = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    @(posedge clk);
    #1;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 ||
           a_if.o_win_valid || b_if.o_win_valid || c_if.o_win_valid) begin
      @(posedge clk);
      #1;
      g++;
      if (g > 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout dut0: got pending windows, expected drained");
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int diffs;
    a_if.i_valid = 1'b0; a_if.i_sof = 1'b0; a_if.i_pixel = '0; a_if.i_win_ready = 1'b1;
    b_if.i_valid = 1'b0; b_if.i_sof = 1'b0; b_if.i_pixel = '0; b_if.i_win_ready = 1'b1;
    c_if.i_valid = 1'b0; c_if.i_sof = 1'b0; c_if.i_pixel = '0; c_if.i_win_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chki("rst_win_valid", 0, int'(a_if.o_win_valid), 0);
    chk ("rst_window",    0, 256'(a_if.o_window), '0);
    chki("rst_frame_done", 0, int'(a_if.o_frame_done), 0);
    chki("rst_ready",     0, int'(a_if.o_ready), 1);
    chki("rst_win_valid", 1, int'(b_if.o_win_valid), 0);
    chki("rst_ready",     1, int'(b_if.o_ready), 1);
    chki("rst_win_valid", 2, int'(c_if.o_win_valid), 0);
    chk ("rst_window",    2, 256'(c_if.o_window), '0);
    @(posedge clk);
    #1;

    // Single frame, stride 1 and stride 2 side by side.
    clear_stats();
    stream(3'b011, 784, 0, 1'b1);
    drain();
    chki("count_s1", 0, hs_cnt[0], 576);
    chki("count_s2", 1, hs_cnt[1], 144);
    chki("frame_done_s1", 0, fd_cnt[0], 1);
    chki("frame_done_s2", 1, fd_cnt[1], 1);
    chki("first_tl", 0, int'(elem(get_cap(0, 0), 5, 1, 0, 0, 0)), 1);
    chki("first_br", 0, int'(elem(get_cap(0, 0), 5, 1, 4, 4, 0)), 117);
    chki("second_tl", 0, int'(elem(get_cap(0, 1), 5, 1, 0, 0, 0)), 2);
    chki("second_br", 0, int'(elem(get_cap(0, 1), 5, 1, 4, 4, 0)), 118);
    chki("last_tl", 0, int'(elem(get_cap(0, 575), 5, 1, 0, 0, 0)), 156);
    chki("last_br", 0, int'(elem(get_cap(0, 575), 5, 1, 4, 4, 0)), 16);
    chki("s2_first_tl", 1, int'(elem(get_cap(1, 0), 5, 1, 0, 0, 0)), 1);
    chki("s2_second_tl", 1, int'(elem(get_cap(1, 1), 5, 1, 0, 0, 0)), 3);
    chki("s2_row2_tl", 1, int'(elem(get_cap(1, 12), 5, 1, 0, 0, 0)), 57);
`ifdef LBW_COORD_EN
    chki("last_x", 0, last_x, 23);
    chki("last_y", 0, last_y, 23);
`endif
    ref_a = cap[0];

    // Random downstream backpressure, stride 1.
    clear_stats();
    stall_cnt = 0;
    bp = 1'b1;
    stream(3'b001, 784, 0, 1'b1);
    drain();
    bp = 1'b0;
    @(posedge clk);
    #1 a_if.i_win_ready = 1'b1;
    chki("bp_count", 0, hs_cnt[0], 576);
    chki("bp_frame_done", 0, fd_cnt[0], 1);
    chki("bp_stalls_seen", 0, int'(stall_cnt > 0), 1);
    diffs = (cap[0].size() == ref_a.size()) ? 0 : 1;
    for (int i = 0; i < cap[0].size() && i < ref_a.size(); i++)
      if (cap[0][i] !== ref_a[i]) diffs++;
    chki("bp_sequence_diffs", 0, diffs, 0);

    // Three packed channels, 3x3 window over 6x6.
    clear_stats();
    stream(3'b100, 36, 1, 1'b1);
    drain();
    chki("ci3_count", 2, hs_cnt[2], 16);
    chki("ci3_frame_done", 2, fd_cnt[2], 1);
    chki("ci3_first_ch0", 2, int'(elem(get_cap(2, 0), 3, 3, 0, 0, 0)), 0);
    chki("ci3_first_ch1", 2, int'(elem(get_cap(2, 0), 3, 3, 0, 0, 1)), 64);
    chki("ci3_first_22ch2", 2, int'(elem(get_cap(2, 0), 3, 3, 2, 2, 2)), 142);
    chki("ci3_last_ch0", 2, int'(elem(get_cap(2, 15), 3, 3, 0, 0, 0)), 21);
    chki("ci3_last_22ch1", 2, int'(elem(get_cap(2, 15), 3, 3, 2, 2, 1)), 99);

    // Reset partway through a frame.
    stream(3'b001, 300, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chki("midrst_win_valid", 0, int'(a_if.o_win_valid), 0);
    @(posedge clk);
    #1;
    clear_stats();
    stream(3'b001, 784, 0, 1'b0);
    drain();
    chki("midrst_count", 0, hs_cnt[0], 576);
    chki("midrst_frame_done", 0, fd_cnt[0], 1);
    chki("midrst_first_tl", 0, int'(elem(get_cap(0, 0), 5, 1, 0, 0, 0)), 1);
    chki("midrst_first_br", 0, int'(elem(get_cap(0, 0), 5, 1, 4, 4, 0)), 117);

    // Frame aborted by start-of-frame after 400 pixels.
    clear_stats();
    stream(3'b001, 400, 2, 1'b1);
    drain();
    chki("abort_frame_done", 0, fd_cnt[0], 0);
    clear_stats();
    stream(3'b001, 784, 0, 1'b1);
    drain();
    chki("sof_count", 0, hs_cnt[0], 576);
    chki("sof_frame_done", 0, fd_cnt[0], 1);
    chki("sof_first_br", 0, int'(elem(get_cap(0, 0), 5, 1, 4, 4, 0)), 117);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/line_buffer_window_gen.md
Name: line_buffer_window_gen

Overview:
- Streaming sliding-window generator for the CNN front end.
- Takes raster-order pixels with CI channels packed per pixel and buffers KY-1 lines.
- Emits KX x KY windows at a configurable stride, with valid/ready backpressure on both sides.
- Drives the conv MAC array. Successor to the fixed 5x5, single-channel, non-stalling line buffer.

Parameters:
- I_F_BW, 8, bits per channel sample.
- CI, 1, channels packed per pixel.
- KX, 5, window width (>=2).
- KY, 5, window height (>=2).
- IX, 28, image width in pixels (>=KX).
- IY, 28, image height in pixels (>=KY).
- STRIDE, 1, horizontal and vertical window stride (1..KX).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- i_sof  in  1  start of frame; qualified by i_valid & o_ready; marks pixel (0,0) and clears counters before that pixel is used.
- i_valid  in  1  input pixel valid.
- i_pixel  in  CI*I_F_BW  pixel; channel ch at [ch*I_F_BW +: I_F_BW].
- o_ready  out  1  input accept.
- o_win_valid  out  1  window valid.
- i_win_ready  in  1  downstream accept.
- o_window  out  KX*KY*CI*I_F_BW  element (ky,kx,ch) at [((ky*KX+kx)*CI+ch)*I_F_BW +: I_F_BW]; ky=0 is the oldest row, kx=0 is the leftmost column.
- o_frame_done  out  1  one-cycle pulse when the last window of a frame is accepted.

Behaviour:
- Reset: o_win_valid=0, o_frame_done=0, o_window=0, col=0, row=0; o_ready=1 in the cycle after reset deasserts. Line-buffer RAM contents are don't-care.
- Input accept: a pixel is accepted when i_valid & o_ready.
- o_ready = !o_win_valid | i_win_ready. This is combinational; the block stalls input only while a window is held.
- On each accepted pixel at (row,col):
  - Form a column of KY samples: the line-buffer rows at col plus the new pixel.
  - Shift the window register left by one column.
  - Write the line buffer.
  - Advance col; on wrap to 0, advance row.
- Emit condition: col>=KX-1, row>=KY-1, (col-(KX-1))%STRIDE==0, and (row-(KY-1))%STRIDE==0.
- When the emit condition holds, o_window/o_win_valid register next cycle. Latency is 1 cycle from accept of the bottom-right pixel.
- o_window is held stable while o_win_valid & !i_win_ready. o_win_valid clears on accept unless a new window loads the same cycle.
- Window count per frame = ((IX-KX)/STRIDE+1)*((IY-KY)/STRIDE+1).
- End of frame: after the pixel at (IY-1,IX-1) is accepted, row and col wrap to 0. o_frame_done pulses in the cycle the final window handshakes.
- i_sof on an accepted pixel treats that pixel as (0,0):
  - Any held window stays until accepted.
  - No o_frame_done is generated for the truncated frame.
- Line-buffer history older than the current frame must never appear in an emitted window. This is guaranteed by the row>=KY-1 gating.
- Simultaneous accept of an output window and load of a new one: the new window wins and o_win_valid stays 1.
- Reset mid-frame: the next pixel is (0,0). No stale window is emitted.
- No arithmetic is performed; samples pass through unchanged.
- Line buffer: KY-1 rows of IX*CI*I_F_BW bits, implemented as a circular column-indexed RAM with a single read and write per accepted pixel.

Optional Feature:
- Macro LBW_COORD_EN.
- Defined: adds outputs o_win_x [$clog2(IX)-1:0] and o_win_y [$clog2(IY)-1:0]. They give the top-left pixel coordinate of the current o_window, registered with o_window and held with it.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Single-frame count (defaults):
  - Stimulus: stream 784 pixels, pixel(r,c) = (r*28+c+1) mod 256, i_win_ready=1.
  - Expected: exactly 576 windows; first window (0,0)=1, (4,4)=117; second window (0,0)=2, (4,4)=118; last window (0,0)=156, (4,4)=16; one o_frame_done.
- STRIDE=2, same stream:
  - Expected: 144 windows.
  - First window top-left=1; second top-left=3; first window of the second output row top-left=57.
- Backpressure, stride 1:
  - Stimulus: toggle i_win_ready randomly at 50%.
  - Expected: o_window stable while stalled; o_ready low only when held & !i_win_ready; identical window sequence to the first scenario; no pixel lost.
- CI=3, KX=KY=3, IX=IY=6:
  - Stimulus: channel ch = pixel index + 64*ch.
  - Expected: 16 windows; channel fields correctly packed per element.
- Reset mid-frame:
  - Stimulus: assert reset after 300 pixels, then stream a full frame.
  - Expected: o_win_valid=0 in the cycle after reset; exactly 576 windows after reset; first window matches the first scenario.
- i_sof mid-frame:
  - Stimulus: assert i_sof at pixel 400, then stream 784 pixels.
  - Expected: no o_frame_done for the aborted frame; the new frame yields 576 windows and one o_frame_done.
- With LBW_COORD_EN defined:
  - Expected: o_win_x/o_win_y sequence (0,0),(1,0)..(23,0),(0,1) ... (23,23).
